// File: rtl/pong_ball_ctrl.sv
// Ball sequencer for pong: paces X/Y counter strobes, owns ball direction,
// resolves wall bounces, paddle hits and goals, and runs the serve/score FSM.
module pong_ball_ctrl #(
  parameter int unsigned BIT_WIDTH = 10,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MAX     = 479,
  parameter int unsigned PAD_L_X   = 16,
  parameter int unsigned PAD_R_X   = 623,
  parameter int unsigned PADDLE_H  = 64,
  parameter int unsigned STEP_DIV  = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] ball_x,
  input  logic [BIT_WIDTH-1:0] ball_y,
  input  logic [BIT_WIDTH-1:0] pad_l_y,
  input  logic [BIT_WIDTH-1:0] pad_r_y,
  output logic                 ctr_load,
  output logic                 x_inc,
  output logic                 x_dec,
  output logic                 y_inc,
  output logic                 y_dec,
  output logic                 score_l,
  output logic                 score_r,
  output logic                 playing
);

  localparam int unsigned PW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned BW1 = BIT_WIDTH + 1;

  localparam logic [PW-1:0]        PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [BIT_WIDTH-1:0] X_MAX_V    = BIT_WIDTH'(X_MAX);
  localparam logic [BIT_WIDTH-1:0] Y_MAX_V    = BIT_WIDTH'(Y_MAX);
  localparam logic [BIT_WIDTH-1:0] HIT_R_X    = BIT_WIDTH'(PAD_R_X - 1);
  localparam logic [BIT_WIDTH-1:0] HIT_L_X    = BIT_WIDTH'(PAD_L_X + 1);
  localparam logic [BIT_WIDTH:0]   PAD_SPAN   = BW1'(PADDLE_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    MOVE,
    SCORED
  } state_e;

  state_e        state_q;
  logic          dir_x_q;
  logic          dir_y_q;
  logic [PW-1:0] presc_q;

  logic [BIT_WIDTH:0] by_w;
  logic [BIT_WIDTH:0] pr_top;
  logic [BIT_WIDTH:0] pl_top;
  logic [BIT_WIDTH:0] pr_bot;
  logic [BIT_WIDTH:0] pl_bot;
  logic               in_pad_r;
  logic               in_pad_l;
  logic               step;
  logic               goal_l;
  logic               goal_r;
  logic               hit_r;
  logic               hit_l;
  logic               wall_bot;
  logic               wall_top;

  // Paddle span bottom is one bit wider so a paddle near the bus limit cannot wrap.
  assign by_w     = {1'b0, ball_y};
  assign pr_top   = {1'b0, pad_r_y};
  assign pl_top   = {1'b0, pad_l_y};
  assign pr_bot   = pr_top + PAD_SPAN;
  assign pl_bot   = pl_top + PAD_SPAN;
  assign in_pad_r = (by_w >= pr_top) && (by_w <= pr_bot);
  assign in_pad_l = (by_w >= pl_top) && (by_w <= pl_bot);

  assign step     = (state_q == MOVE) && (presc_q == PRESC_LAST);
  assign goal_l   = dir_x_q && (ball_x == X_MAX_V);
  assign goal_r   = !dir_x_q && (ball_x == '0);
  assign hit_r    = dir_x_q && (ball_x == HIT_R_X) && in_pad_r;
  assign hit_l    = !dir_x_q && (ball_x == HIT_L_X) && in_pad_l;
  assign wall_bot = dir_y_q && (ball_y == Y_MAX_V);
  assign wall_top = !dir_y_q && (ball_y == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      presc_q  <= '0;
      ctr_load <= 1'b1;
      x_inc    <= 1'b0;
      x_dec    <= 1'b0;
      y_inc    <= 1'b0;
      y_dec    <= 1'b0;
      score_l  <= 1'b0;
      score_r  <= 1'b0;
      playing  <= 1'b0;
    end else begin
      x_inc   <= 1'b0;
      x_dec   <= 1'b0;
      y_inc   <= 1'b0;
      y_dec   <= 1'b0;
      score_l <= 1'b0;
      score_r <= 1'b0;

      case (state_q)
        IDLE: begin
          ctr_load <= 1'b1;
          playing  <= 1'b0;
          if (start) begin
            state_q  <= SERVE;
            ctr_load <= 1'b0;
          end
        end

        SERVE: begin
          presc_q <= '0;
          playing <= 1'b1;
          state_q <= MOVE;
        end

        MOVE: begin
          if (!step) begin
            presc_q <= presc_q + 1'b1;
          end else begin
            presc_q <= '0;
            // A goal suppresses all motion strobes and leaves dir_y untouched.
            if (goal_l || goal_r) begin
              score_l  <= goal_l;
              score_r  <= goal_r;
              dir_x_q  <= goal_r;
              ctr_load <= 1'b1;
              playing  <= 1'b0;
              state_q  <= SCORED;
            end else begin
              if (hit_r) begin
                dir_x_q <= 1'b0;
                x_dec   <= 1'b1;
              end else if (hit_l) begin
                dir_x_q <= 1'b1;
                x_inc   <= 1'b1;
              end else begin
                x_inc <= dir_x_q;
                x_dec <= !dir_x_q;
              end

              if (wall_bot) begin
                dir_y_q <= 1'b0;
                y_dec   <= 1'b1;
              end else if (wall_top) begin
                dir_y_q <= 1'b1;
                y_inc   <= 1'b1;
              end else begin
                y_inc <= dir_y_q;
                y_dec <= !dir_y_q;
              end
            end
          end
        end

        SCORED: begin
          ctr_load <= 1'b1;
          playing  <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          state_q  <= IDLE;
          ctr_load <= 1'b1;
          playing  <= 1'b0;
        end
      endcase
    end
  end

endmodule
